// File: rtl/fwd_scoreboard.sv
// Operand-forwarding selector plus per-register busy scoreboard for an in-order pipeline.
// Latency: fwd_sel/stall/issue are combinational; busy counters and stall_cycles update on the rising clk edge.
// Backpressure: stall holds ID/PC while any live source is still busy; there is no internal buffering, and flush drops the ID slot.
module fwd_scoreboard #(
   parameter int AW   = 5,
   parameter int NSRC = 2,
   parameter int CW   = 3,
   parameter int SW   = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 id_valid,
   input  logic [NSRC*AW-1:0]   id_rs,
   input  logic [AW-1:0]        id_rd,
   input  logic                 id_reg_write,
   input  logic [CW-1:0]        id_lat,
   input  logic                 flush,
   input  logic [NSRC*AW-1:0]   ex_rs,
   input  logic [AW-1:0]        mem_rd,
   input  logic [AW-1:0]        wb_rd,
   input  logic                 mem_reg_write,
   input  logic                 wb_reg_write,
   output logic [NSRC*2-1:0]    fwd_sel,
   output logic                 stall,
   output logic                 issue,
   output logic [SW-1:0]        stall_cycles
);

   localparam int NREG = 1 << AW;

   // busy[r] counts the cycles left before register r is forwardable from MEM.
   // Entry 0 is held at zero so r0 can never look busy.
   logic [CW-1:0] busy     [NREG];
   logic [CW-1:0] busy_nxt [NREG];

   logic [NSRC-1:0] src_hazard;
   logic            id_live;
   logic            load_en;

   // ------------------------------------------------------------------
   // EX-stage forwarding: MEM result wins over WB, r0 is never forwarded.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NSRC; i++) begin : g_fwd
      logic [AW-1:0] ex_src;
      logic          mem_hit;
      logic          wb_hit;

      assign ex_src  = ex_rs[i*AW +: AW];
      assign mem_hit = mem_reg_write && (ex_src != '0) && (ex_src == mem_rd);
      assign wb_hit  = wb_reg_write  && (ex_src != '0) && (ex_src == wb_rd);
      assign fwd_sel[i*2 +: 2] = mem_hit ? 2'b01 :
                                 wb_hit  ? 2'b10 : 2'b00;
   end

   // ------------------------------------------------------------------
   // ID-stage hazard check against the pre-update counters, so an
   // instruction reading its own destination sees the old state.
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NSRC; i++) begin : g_haz
      logic [AW-1:0] id_src;

      assign id_src        = id_rs[i*AW +: AW];
      assign src_hazard[i] = (id_src != '0) && (busy[id_src] != '0);
   end

   // A flushed slot neither stalls, issues nor loads a counter.
   assign id_live = id_valid && !flush;
   assign stall   = id_live && (|src_hazard);
   assign issue   = id_live && !stall;

   // Only real, multi-cycle writers to a nonzero register occupy the scoreboard.
   assign load_en = issue && id_reg_write && (id_rd != '0) && (id_lat != '0);

   // Next counter values: age every live entry, then let a new issue overwrite its rd (WAW is not blocked).
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         busy_nxt[r] = (busy[r] != '0) ? (busy[r] - CW'(1)) : '0;
      end
      if (load_en) begin
         busy_nxt[id_rd] = id_lat;
      end
      busy_nxt[0] = '0;
   end

   // Scoreboard state register, cleared asynchronously.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < NREG; r++) begin
            busy[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            busy[r] <= busy_nxt[r];
         end
      end
   end

   // Saturating count of stalled cycles for performance monitoring.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != {SW{1'b1}})) begin
         stall_cycles <= stall_cycles + SW'(1);
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed hazard scenarios followed by random traffic.
// Two instances share all inputs; the second uses a 4-bit stall counter to exercise saturation.
module tb_fwd_scoreboard;

   localparam int AW   = 5;
   localparam int NSRC = 2;
   localparam int CW   = 3;
   localparam int SW   = 16;
   localparam int NREG = 1 << AW;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 id_valid;
   logic [NSRC*AW-1:0]   id_rs;
   logic [AW-1:0]        id_rd;
   logic                 id_reg_write;
   logic [CW-1:0]        id_lat;
   logic                 flush;
   logic [NSRC*AW-1:0]   ex_rs;
   logic [AW-1:0]        mem_rd;
   logic [AW-1:0]        wb_rd;
   logic                 mem_reg_write;
   logic                 wb_reg_write;
   logic [NSRC*2-1:0]    fwd_sel;
   logic [NSRC*2-1:0]    fwd_sel4;
   logic                 stall;
   logic                 stall4;
   logic                 issue;
   logic                 issue4;
   logic [SW-1:0]        stall_cycles;
   logic [3:0]           stall_cycles4;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: remaining busy cycles per register and stall totals.
   int mb [NREG];
   int msc16;
   int msc4;
   logic [NSRC*2-1:0] exp_fwd;
   logic              exp_stall;
   logic              exp_issue;

   fwd_scoreboard #(.AW(AW), .NSRC(NSRC), .CW(CW), .SW(SW)) dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_lat(id_lat), .flush(flush), .ex_rs(ex_rs),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
      .wb_reg_write(wb_reg_write), .fwd_sel(fwd_sel), .stall(stall), .issue(issue),
      .stall_cycles(stall_cycles)
   );

   fwd_scoreboard #(.AW(AW), .NSRC(NSRC), .CW(CW), .SW(4)) dut4 (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_lat(id_lat), .flush(flush), .ex_rs(ex_rs),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
      .wb_reg_write(wb_reg_write), .fwd_sel(fwd_sel4), .stall(stall4), .issue(issue4),
      .stall_cycles(stall_cycles4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) mb[r] = 0;
      msc16 = 0;
      msc4  = 0;
   endtask

   // Expected combinational outputs from the current model state and inputs.
   task automatic model_eval();
      logic [1:0] sel;
      int e;
      int d;
      exp_fwd   = '0;
      exp_stall = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         e = int'(ex_rs[i*AW +: AW]);
         d = int'(id_rs[i*AW +: AW]);
         if (e != 0 && mem_reg_write && e == int'(mem_rd))     sel = 2'b01;
         else if (e != 0 && wb_reg_write && e == int'(wb_rd))  sel = 2'b10;
         else                                                 sel = 2'b00;
         exp_fwd[i*2 +: 2] = sel;
         if (d != 0 && mb[d] > 0) exp_stall = 1'b1;
      end
      exp_stall = exp_stall && id_valid && !flush;
      exp_issue = id_valid && !flush && !exp_stall;
   endtask

   // Advance the model by one clock edge.
   task automatic model_clock();
      for (int r = 0; r < NREG; r++) if (mb[r] > 0) mb[r] = mb[r] - 1;
      if (exp_issue && id_reg_write && id_rd != 0 && id_lat != 0) mb[id_rd] = int'(id_lat);
      if (exp_stall) begin
         if (msc16 < 65535) msc16++;
         if (msc4 < 15) msc4++;
      end
   endtask

   // One clock cycle: check outputs at the falling edge, then step the model on the rising edge.
   task automatic step(output logic stl, output logic iss);
      @(negedge clk);
      model_eval();
      chk("fwd_sel", fwd_sel, exp_fwd);
      chk("fwd_sel_sw4", fwd_sel4, exp_fwd);
      chk("stall", stall, exp_stall);
      chk("stall_sw4", stall4, exp_stall);
      chk("issue", issue, exp_issue);
      chk("issue_sw4", issue4, exp_issue);
      chk("stall_cycles", stall_cycles, msc16);
      chk("stall_cycles_sw4", stall_cycles4, msc4);
      stl = stall;
      iss = issue;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic set_idle();
      id_valid = 0; id_rs = '0; id_rd = '0; id_reg_write = 0; id_lat = '0; flush = 0;
      ex_rs = '0; mem_rd = '0; wb_rd = '0; mem_reg_write = 0; wb_reg_write = 0;
   endtask

   // Present an instruction in ID: srcs are operand 0 / operand 1.
   task automatic set_id(input int rd, input int lat, input logic we, input int s0, input int s1);
      id_valid = 1; flush = 0;
      id_rd = AW'(rd); id_lat = CW'(lat); id_reg_write = we;
      id_rs[0 +: AW]  = AW'(s0);
      id_rs[AW +: AW] = AW'(s1);
   endtask

   // Keep the current ID instruction presented until it issues; count its stall cycles.
   task automatic count_stalls(output int n, output logic issued);
      logic stl;
      logic iss;
      n = 0;
      issued = 0;
      for (int k = 0; k < 12; k++) begin
         step(stl, iss);
         if (stl) n++;
         if (iss) begin
            issued = 1;
            break;
         end
      end
   endtask

   initial begin
      logic stl;
      logic iss;
      logic issued;
      int   n;

      // Reset state, including outputs driven by inputs while reset is held.
      set_idle();
      rstn = 0;
      model_reset();
      #12;
      chk("rst_stall", stall, 0);
      chk("rst_issue", issue, 0);
      chk("rst_fwd", fwd_sel, 0);
      chk("rst_sc", stall_cycles, 0);
      chk("rst_sc4", stall_cycles4, 0);
      set_id(0, 0, 0, 7, 7);
      ex_rs = {5'd5, 5'd5}; mem_rd = 5'd5; mem_reg_write = 1;
      #1;
      chk("rst_issue_live", issue, 1);
      chk("rst_stall_live", stall, 0);
      chk("rst_fwd_live", fwd_sel, 4'b0101);
      @(posedge clk);
      #1;
      set_idle();
      rstn = 1;

      // Forwarding patterns.
      ex_rs = {5'd5, 5'd5}; mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1; wb_reg_write = 1;
      #1 chk("fwd_mem_prio", fwd_sel, 4'b0101);
      mem_reg_write = 0;
      #1 chk("fwd_wb", fwd_sel, 4'b1010);
      ex_rs = '0; mem_reg_write = 1;
      #1 chk("fwd_r0", fwd_sel, 4'b0000);
      ex_rs = {5'd6, 5'd5}; mem_rd = 5'd6; wb_rd = 5'd5;
      #1 chk("fwd_mixed", fwd_sel, 4'b0110);
      step(stl, iss);
      set_idle();

      // Load-use: one stall.
      set_id(7, 1, 1, 0, 0);
      step(stl, iss);
      set_id(0, 0, 0, 7, 0);
      count_stalls(n, issued);
      chk("ld_use_stalls", n, 1);
      chk("ld_use_issued", issued, 1);
      chk("ld_use_sc", stall_cycles, 1);

      // Multi-cycle producer read on operand 1 the next cycle: counter 4 -> 4 stalls.
      set_id(9, 4, 1, 0, 0);
      step(stl, iss);
      set_id(0, 0, 0, 0, 9);
      count_stalls(n, issued);
      chk("mc_stalls", n, 4);
      chk("mc_issued", issued, 1);
      chk("mc_sc", stall_cycles, 5);

      // Flush with busy[9]=2: no stall, no issue, no load; counter drains two cycles later.
      set_id(9, 3, 1, 0, 0);
      step(stl, iss);
      set_idle();
      step(stl, iss);
      set_id(9, 7, 1, 0, 9);
      flush = 1;
      step(stl, iss);
      chk("flush_stall", stl, 0);
      chk("flush_issue", iss, 0);
      set_idle();
      step(stl, iss);
      set_id(0, 0, 0, 0, 9);
      step(stl, iss);
      chk("flush_drained_stall", stl, 0);
      chk("flush_drained_issue", iss, 1);

      // Load overrides decrement: busy[3]=1 reloaded with 5 -> 5 stalls.
      set_id(3, 2, 1, 0, 0);
      step(stl, iss);
      set_idle();
      step(stl, iss);
      set_id(3, 5, 1, 0, 0);
      step(stl, iss);
      chk("reload_issue", iss, 1);
      set_id(0, 0, 0, 3, 0);
      count_stalls(n, issued);
      chk("reload_stalls", n, 5);

      // Accumulate stalls until the 4-bit counter saturates.
      for (int k = 0; k < 3; k++) begin
         set_id(4, 7, 1, 0, 0);
         step(stl, iss);
         set_id(0, 0, 0, 4, 4);
         count_stalls(n, issued);
         chk("sat_round_stalls", n, 7);
      end
      chk("sat_sc4", stall_cycles4, 15);

      // Asynchronous reset in the middle of a stall.
      set_id(4, 7, 1, 0, 0);
      step(stl, iss);
      set_id(0, 0, 0, 4, 0);
      step(stl, iss);
      chk("pre_rst_stall", stall, 1);
      #2 rstn = 0;
      #1;
      chk("async_rst_stall", stall, 0);
      chk("async_rst_issue", issue, 1);
      chk("async_rst_sc", stall_cycles, 0);
      chk("async_rst_sc4", stall_cycles4, 0);
      model_reset();
      rstn = 1;
      step(stl, iss);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         id_valid      = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 9) == 0);
         id_rd         = AW'($urandom_range(0, 7));
         id_reg_write  = 1'($urandom_range(0, 1));
         id_lat        = CW'($urandom_range(0, 7));
         mem_rd        = AW'($urandom_range(0, 7));
         wb_rd         = AW'($urandom_range(0, 7));
         mem_reg_write = 1'($urandom_range(0, 1));
         wb_reg_write  = 1'($urandom_range(0, 1));
         for (int i = 0; i < NSRC; i++) begin
            id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
            ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
         end
         if (k == 300) begin
            #2 rstn = 0;
            #1 model_reset();
            rstn = 1;
         end
         step(stl, iss);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
